// File: rtl/bcd_adder_sched.sv
// bcd_adder_sched
// Round-robin scheduler that shares one 3-digit BCD adder between two
// requesters. It validates and registers the granted requester's operands
// and drives the adder through load, start and wait. It then returns the
// 4-digit sum with a one-cycle done pulse. Invalid BCD operands and adder
// timeouts are reported through err, which pulses together with done.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   req0/req1             request levels, held until the matching done
//   opa0/opb0, opa1/opb1  packed 3-digit BCD operands, sampled at grant
//   done0/done1           one-cycle completion pulse to the granted side
//   err                   failure flag, coincident with done
//   result                4-digit BCD sum, held after done
//   gnt                   one-hot grant, high from grant through DONE
//   busy                  high whenever the scheduler is not idle
//   add_a/add_b           registered operands to the adder
//   add_load, add_start   adder load / start_conv strobes
//   add_ready, add_sum    adder ready flag and 4-digit sum
module bcd_adder_sched #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [11:0] opa0,
    input  logic [11:0] opb0,
    input  logic [11:0] opa1,
    input  logic [11:0] opb1,
    output logic        done0,
    output logic        done1,
    output logic        err,
    output logic [15:0] result,
    output logic [1:0]  gnt,
    output logic        busy,
    output logic [11:0] add_a,
    output logic [11:0] add_b,
    output logic        add_load,
    output logic        add_start,
    input  logic        add_ready,
    input  logic [15:0] add_sum
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state, state_d;
    logic            ptr, ptr_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [1:0]      gnt_d;
    logic            busy_d;
    logic            done0_d, done1_d, err_d;
    logic            add_load_d, add_start_d;
    logic [11:0]     add_a_d, add_b_d;
    logic [15:0]     result_d;

    logic            sel;
    logic [11:0]     sel_a, sel_b;

    // True when every nibble is a decimal digit.
    function automatic logic bcd_ok(input logic [11:0] v);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // A lone request wins outright; ptr only arbitrates a tie.
    assign sel   = (req0 && req1) ? ptr : req1;
    assign sel_a = sel ? opa1 : opa0;
    assign sel_b = sel ? opb1 : opb0;

    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        cnt_d       = cnt;
        gnt_d       = gnt;
        add_a_d     = add_a;
        add_b_d     = add_b;
        result_d    = result;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        err_d       = 1'b0;
        add_load_d  = 1'b0;
        add_start_d = 1'b0;

        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    gnt_d   = sel ? 2'b10 : 2'b01;
                    add_a_d = sel_a;
                    add_b_d = sel_b;
                    if (bcd_ok(sel_a) && bcd_ok(sel_b)) begin
                        state_d    = S_LOAD;
                        add_load_d = 1'b1;
                    end else begin
                        state_d  = S_DONE;
                        err_d    = 1'b1;
                        result_d = '0;
                        done0_d  = ~sel;
                        done1_d  = sel;
                    end
                end
            end
            S_LOAD: begin
                state_d     = S_START;
                add_start_d = 1'b1;
            end
            S_START: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                cnt_d = cnt + CW'(1);
                // cnt == 0 is the first WAIT cycle, where ready may be stale.
                if ((cnt != '0) && add_ready) begin
                    state_d  = S_DONE;
                    result_d = add_sum;
                    done0_d  = gnt[0];
                    done1_d  = gnt[1];
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_d  = S_DONE;
                    err_d    = 1'b1;
                    result_d = '0;
                    done0_d  = gnt[0];
                    done1_d  = gnt[1];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                ptr_d   = gnt[0];
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= 1'b0;
            cnt       <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err       <= 1'b0;
            add_load  <= 1'b0;
            add_start <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            result    <= '0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            cnt       <= cnt_d;
            gnt       <= gnt_d;
            busy      <= busy_d;
            done0     <= done0_d;
            done1     <= done1_d;
            err       <= err_d;
            add_load  <= add_load_d;
            add_start <= add_start_d;
            add_a     <= add_a_d;
            add_b     <= add_b_d;
            result    <= result_d;
        end
    end

endmodule

// File: tb/tb_bcd_adder_sched.sv
// Self-checking bench for bcd_adder_sched: directed timing sequences, a
// table of two-requester scenarios, and randomized requests checked against
// a decimal-arithmetic reference and a round-robin order model.
module tb_bcd_adder_sched;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [11:0] opa0 = '0, opb0 = '0, opa1 = '0, opb1 = '0;
    logic        done0, done1, err, busy, add_load, add_start;
    logic [15:0] result;
    logic [1:0]  gnt;
    logic [11:0] add_a, add_b;
    logic        add_ready = 1'b0;
    logic [15:0] add_sum = '0;

    bcd_adder_sched #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .opa0(opa0), .opb0(opb0), .opa1(opa1), .opb1(opb1),
        .done0(done0), .done1(done1), .err(err), .result(result),
        .gnt(gnt), .busy(busy),
        .add_a(add_a), .add_b(add_b),
        .add_load(add_load), .add_start(add_start),
        .add_ready(add_ready), .add_sum(add_sum)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int m_ptr  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic int bcd2int(input logic [11:0] x);
        int d;
        logic [11:0] t;
        d = 0;
        for (int i = 2; i >= 0; i--) begin
            t = x >> (4 * i);
            d = d * 10 + int'(t[3:0]);
        end
        return d;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic bcd_valid(input logic [11:0] x);
        logic [11:0] t;
        for (int i = 0; i < 3; i++) begin
            t = x >> (4 * i);
            if (t[3:0] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [15:0] bcd_add(input logic [11:0] a, input logic [11:0] b);
        return int2bcd(bcd2int(a) + bcd2int(b));
    endfunction

    function automatic logic [11:0] rand_op();
        logic [11:0] r;
        for (int i = 0; i < 3; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 9) == 0) r[4*$urandom_range(0, 2) +: 4] = 4'($urandom_range(10, 15));
        return r;
    endfunction

    // ---------------- adder model ----------------
    int          lat_cfg    = 2;
    bit          stale_mode = 1'b0;
    bit          ready_tie0 = 1'b0;
    int          cd         = -1;
    logic [11:0] m_a = '0, m_b = '0;
    int          n_load = 0, n_start = 0;

    // Ready rises lat_cfg cycles after start. In stale mode, the previous
    // ready/sum is kept through START and the first WAIT cycle, dropped,
    // and the new sum appears three cycles after start.
    always @(negedge clk) begin
        if (add_load) begin
            m_a = add_a;
            m_b = add_b;
            n_load++;
        end
        if (add_start) begin
            n_start++;
            cd = stale_mode ? 3 : lat_cfg;
            if (!stale_mode) add_ready = 1'b0;
        end else if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) begin
                if (!ready_tie0) begin
                    add_ready = 1'b1;
                    add_sum   = bcd_add(m_a, m_b);
                end
            end else if (stale_mode && cd == 1) begin
                add_ready = 1'b0;
            end
        end
    end

    // ---------------- scenario record ----------------
    typedef struct {
        logic [1:0]  m;
        logic [11:0] a0, b0, a1, b1;
        int          lat;
        logic [15:0] r0, r1;
        logic        e0, e1;
        int          first;
    } vec_t;

    function automatic void expect_side(input logic [11:0] a, input logic [11:0] b, input int lat,
                                        output logic [15:0] r, output logic e);
        if (!bcd_valid(a) || !bcd_valid(b) || lat > TO) begin
            r = '0;
            e = 1'b1;
        end else begin
            r = bcd_add(a, b);
            e = 1'b0;
        end
    endfunction

    // Called at a negedge; raises the requests, serves them, checks results.
    task automatic serve(input vec_t v);
        logic [1:0] pend;
        int first, l0, s0, nvalid;
        logic gbad;
        pend  = v.m;
        first = -1;
        gbad  = 1'b0;
        l0    = n_load;
        s0    = n_start;
        nvalid = 0;
        if (v.m[0] && bcd_valid(v.a0) && bcd_valid(v.b0)) nvalid++;
        if (v.m[1] && bcd_valid(v.a1) && bcd_valid(v.b1)) nvalid++;
        lat_cfg = v.lat;
        opa0 = v.a0; opb0 = v.b0; opa1 = v.a1; opb1 = v.b1;
        req0 = v.m[0];
        req1 = v.m[1];
        for (int n = 0; n < 200 && pend != 2'b00; n++) begin
            @(negedge clk);
            if (!(gnt == 2'b00 || gnt == 2'b01 || gnt == 2'b10)) gbad = 1'b1;
            if (done0 && done1) gbad = 1'b1;
            if (done0) begin
                chk("done0_pending", pend[0], 1'b1);
                chk("done0_gnt", gnt, 2'b01);
                chk("result0", result, v.r0);
                chk("err0", err, v.e0);
                if (first < 0) first = 0;
                pend[0] = 1'b0;
                req0    = 1'b0;
                m_ptr   = 1;
            end
            if (done1) begin
                chk("done1_pending", pend[1], 1'b1);
                chk("done1_gnt", gnt, 2'b10);
                chk("result1", result, v.r1);
                chk("err1", err, v.e1);
                if (first < 0) first = 1;
                pend[1] = 1'b0;
                req1    = 1'b0;
                m_ptr   = 0;
            end
        end
        chk("all_served", pend, 2'b00);
        chk("order", 64'(first), 64'(v.first));
        chk("load_count", 64'(n_load - l0), 64'(nvalid));
        chk("start_count", 64'(n_start - s0), 64'(nvalid));
        chk("gnt_onehot", gbad, 1'b0);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    vec_t tbl[8];
    vec_t rv;
    logic sawdone;
    int   l_snap;

    initial begin
        tbl[0] = '{2'd3, 12'h999, 12'h999, 12'h007, 12'h015, 3,  16'h1998, 16'h0022, 1'b0, 1'b0, 0};
        tbl[1] = '{2'd3, 12'h999, 12'h999, 12'h007, 12'h015, 3,  16'h1998, 16'h0022, 1'b0, 1'b0, 0};
        tbl[2] = '{2'd1, 12'h123, 12'h456, 12'h000, 12'h000, 2,  16'h0579, 16'h0000, 1'b0, 1'b0, 0};
        tbl[3] = '{2'd3, 12'h500, 12'h500, 12'h0A0, 12'h000, 4,  16'h1000, 16'h0000, 1'b0, 1'b1, 1};
        tbl[4] = '{2'd2, 12'h000, 12'h000, 12'h1A3, 12'h001, 2,  16'h0000, 16'h0000, 1'b0, 1'b1, 1};
        tbl[5] = '{2'd1, 12'h001, 12'h002, 12'h000, 12'h000, 16, 16'h0003, 16'h0000, 1'b0, 1'b0, 0};
        tbl[6] = '{2'd2, 12'h000, 12'h000, 12'h001, 12'h002, 17, 16'h0000, 16'h0000, 1'b0, 1'b1, 1};
        tbl[7] = '{2'd2, 12'h000, 12'h000, 12'h999, 12'h001, 1,  16'h0000, 16'h1000, 1'b0, 1'b0, 1};

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {gnt, busy, done0, done1, err, add_load, add_start, add_a, add_b, result}, '0);
        rst_n = 1'b1;

        // Cycle-exact single operation: 0x123 + 0x456
        @(negedge clk);
        opa0 = 12'h123; opb0 = 12'h456; lat_cfg = 1; req0 = 1'b1;
        @(negedge clk);
        chk("t1_gnt", gnt, 2'b01);
        chk("t1_busy", busy, 1'b1);
        chk("t1_load", add_load, 1'b1);
        chk("t1_start", add_start, 1'b0);
        chk("t1_add_a", add_a, 12'h123);
        chk("t1_add_b", add_b, 12'h456);
        @(negedge clk);
        chk("t2_load", add_load, 1'b0);
        chk("t2_start", add_start, 1'b1);
        @(negedge clk);
        chk("t3_start", add_start, 1'b0);
        chk("t3_done", done0, 1'b0);
        @(negedge clk);
        chk("t4_done_early", done0, 1'b0);
        @(negedge clk);
        chk("t5_done0", done0, 1'b1);
        chk("t5_done1", done1, 1'b0);
        chk("t5_err", err, 1'b0);
        chk("t5_result", result, 16'h0579);
        req0 = 1'b0;
        @(negedge clk);
        chk("t6_done0", done0, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_gnt", gnt, 2'b00);
        chk("t6_result_held", result, 16'h0579);

        // Reset pulse returns ptr to 0 before the table
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;

        for (int i = 0; i < 8; i++) serve(tbl[i]);

        // Stale ready held across START (previous sum 0x1000 still present)
        stale_mode = 1'b1;
        rv = '{2'd1, 12'h250, 12'h250, 12'h000, 12'h000, 3, 16'h0500, 16'h0000, 1'b0, 1'b0, 0};
        serve(rv);
        stale_mode = 1'b0;

        // Invalid operand: done+err one cycle after grant, no adder strobes
        @(negedge clk);
        l_snap = n_load;
        opa1 = 12'h1A3; opb1 = 12'h001; req1 = 1'b1;
        @(negedge clk);
        chk("inv_done1", done1, 1'b1);
        chk("inv_done0", done0, 1'b0);
        chk("inv_err", err, 1'b1);
        chk("inv_result", result, 16'h0000);
        chk("inv_gnt", gnt, 2'b10);
        chk("inv_load", add_load, 1'b0);
        req1 = 1'b0;
        @(negedge clk);
        chk("inv_after_done", done1, 1'b0);
        chk("inv_after_gnt", gnt, 2'b00);
        chk("inv_no_load", 64'(n_load - l_snap), 64'(0));
        m_ptr = 0;

        // Timeout: ready never comes, done+err after TO WAIT cycles
        @(negedge clk);
        ready_tie0 = 1'b1;
        opa0 = 12'h111; opb0 = 12'h222; req0 = 1'b1;
        sawdone = 1'b0;
        for (int k = 1; k <= TO + 2; k++) begin
            @(negedge clk);
            if (done0 || done1) sawdone = 1'b1;
        end
        chk("to_not_early", sawdone, 1'b0);
        @(negedge clk);
        chk("to_done0", done0, 1'b1);
        chk("to_err", err, 1'b1);
        chk("to_result", result, 16'h0000);
        req0 = 1'b0;
        @(negedge clk);
        chk("to_idle_busy", busy, 1'b0);
        chk("to_idle_gnt", gnt, 2'b00);
        ready_tie0 = 1'b0;
        m_ptr = 1;

        // Reset mid-operation (ptr is 1 here), then a tie must go to side 0
        @(negedge clk);
        opa0 = 12'h321; opb0 = 12'h111; lat_cfg = 5; req0 = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", {gnt, busy, done0, done1, err, add_load, add_start, add_a, add_b, result}, '0);
        req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        rv = '{2'd3, 12'h050, 12'h050, 12'h999, 12'h999, 2, 16'h0100, 16'h1998, 1'b0, 1'b0, 0};
        serve(rv);

        // Randomized requests against the reference model
        for (int it = 0; it < 40; it++) begin
            rv.m   = 2'($urandom_range(1, 3));
            rv.a0  = rand_op();
            rv.b0  = rand_op();
            rv.a1  = rand_op();
            rv.b1  = rand_op();
            rv.lat = $urandom_range(1, 20);
            expect_side(rv.a0, rv.b0, rv.lat, rv.r0, rv.e0);
            expect_side(rv.a1, rv.b1, rv.lat, rv.r1, rv.e1);
            if (rv.m == 2'd3) rv.first = m_ptr;
            else              rv.first = rv.m[1] ? 1 : 0;
            serve(rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
